encoder_event_tracker: RTL and testbench

- Sits directly downstream of the rotary encoder sampler/state machine.
- Converts its strobe, direction, click and switch outputs into detent counts, a bounded saturating control value with optional speed acceleration, and short/long press classification.
- Queues discrete events in a 4-deep FIFO with a valid/ready handshake for the CPU register interface.

---
 rtl/encoder_event_tracker.sv | 223 ++++++++++++++++++++++
 tb/tb_encoder_event_tracker.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/encoder_event_tracker.sv
// Turns rotary encoder sampler outputs into a saturating control value, press classification
// and a 4-deep event FIFO. Define ENC_ACCEL_EN to enable the detent speed-acceleration timer.
module encoder_event_tracker #(
    parameter int unsigned VALUE_W           = 8,
    parameter int unsigned MIN_VALUE         = 0,
    parameter int unsigned MAX_VALUE         = 255,
    parameter int unsigned INIT_VALUE        = 128,
    parameter int unsigned ACCEL_WINDOW      = 2000000,
    parameter int unsigned ACCEL_STEP        = 4,
    parameter int unsigned LONG_PRESS_CYCLES = 50000000,
    parameter logic        SW_PRESSED_LEVEL  = 1'b0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enc_state_change_stb,
    input  logic               clockwise,
    input  logic               click,
    input  logic               switch,
    output logic [VALUE_W-1:0] value,
    output logic               evt_valid,
    output logic [1:0]         evt_code,
    input  logic               evt_ready,
    output logic [2:0]         evt_count,
    output logic               overflow,
    input  logic               clear_overflow
);

    localparam logic [VALUE_W:0] MIN_X     = (VALUE_W+1)'(MIN_VALUE);
    localparam logic [VALUE_W:0] MAX_X     = (VALUE_W+1)'(MAX_VALUE);
    localparam logic [VALUE_W:0] STEP_FAST = (VALUE_W+1)'(ACCEL_STEP);
    localparam logic [VALUE_W:0] STEP_ONE  = (VALUE_W+1)'(1);
    localparam int unsigned HOLD_W = (LONG_PRESS_CYCLES > 2) ? $clog2(LONG_PRESS_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);

    typedef enum logic [1:0] {
        SW_IDLE,
        SW_PRESSED,
        SW_HELD
    } sw_state_e;

    logic               click_dly_q;
    logic               detent;
    logic               fast;
    logic [VALUE_W:0]   step;
    logic [VALUE_W:0]   value_x;
    logic [VALUE_W:0]   sum;
    logic [VALUE_W-1:0] value_q, value_d;

    sw_state_e          sw_state_q, sw_state_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic               pressed;
    logic               sw_v;
    logic [1:0]         sw_code;

    logic               skid_v_q, skid_v_d;
    logic [1:0]         skid_code_q, skid_code_d;

    logic [1:0]         mem_q [4];
    logic [1:0]         rd_q, rd_d, wr_q, wr_d;
    logic [2:0]         cnt_q, cnt_d;
    logic               ovf_q, ovf_d;
    logic               push_v;
    logic [1:0]         push_code;
    logic               full, pop, accept, drop;

    assign detent  = enc_state_change_stb && click && !click_dly_q;
    assign pressed = (switch == SW_PRESSED_LEVEL);

`ifdef ENC_ACCEL_EN
    localparam int unsigned ACC_W = $clog2(ACCEL_WINDOW + 1);
    localparam logic [ACC_W-1:0] ACC_MAX = ACC_W'(ACCEL_WINDOW);
    logic [ACC_W-1:0] acc_q, acc_d;

    always_comb begin
        acc_d = acc_q;
        if (detent) begin
            acc_d = '0;
        end else if (acc_q < ACC_MAX) begin
            acc_d = acc_q + ACC_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q <= ACC_MAX;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign fast = (acc_q < ACC_MAX);
`else
    assign fast = 1'b0;
`endif

    // One spare bit keeps the sum/difference from wrapping before the clamp.
    always_comb begin
        step    = fast ? STEP_FAST : STEP_ONE;
        value_x = {1'b0, value_q};
        sum     = value_x + step;
        value_d = value_q;
        if (detent) begin
            if (clockwise) begin
                value_d = (sum > MAX_X) ? MAX_X[VALUE_W-1:0] : sum[VALUE_W-1:0];
            end else if (value_x < (MIN_X + step)) begin
                value_d = MIN_X[VALUE_W-1:0];
            end else begin
                value_d = value_q - step[VALUE_W-1:0];
            end
        end
    end

    always_comb begin
        sw_state_d = sw_state_q;
        hold_d     = hold_q;
        sw_v       = 1'b0;
        sw_code    = 2'b10;
        case (sw_state_q)
            SW_IDLE: begin
                if (pressed) begin
                    sw_state_d = SW_PRESSED;
                    hold_d     = '0;
                end
            end
            SW_PRESSED: begin
                if (!pressed) begin
                    sw_v       = 1'b1;
                    sw_code    = 2'b10;
                    sw_state_d = SW_IDLE;
                end else if (hold_q == HOLD_LAST) begin
                    sw_v       = 1'b1;
                    sw_code    = 2'b11;
                    sw_state_d = SW_HELD;
                end else begin
                    hold_d = hold_q + HOLD_W'(1);
                end
            end
            SW_HELD: begin
                if (!pressed) begin
                    sw_state_d = SW_IDLE;
                end
            end
            default: sw_state_d = SW_IDLE;
        endcase
    end

    // Detents win the push slot; a colliding switch event waits one cycle in the skid.
    always_comb begin
        push_v      = detent || skid_v_q || sw_v;
        push_code   = detent ? (clockwise ? 2'b00 : 2'b01)
                             : (skid_v_q ? skid_code_q : sw_code);
        skid_v_d    = skid_v_q;
        skid_code_d = skid_code_q;
        if (detent) begin
            if (sw_v) begin
                skid_v_d    = 1'b1;
                skid_code_d = sw_code;
            end
        end else if (skid_v_q) begin
            skid_v_d    = sw_v;
            skid_code_d = sw_code;
        end
    end

    always_comb begin
        full   = (cnt_q == 3'd4);
        pop    = (cnt_q != 3'd0) && evt_ready;
        accept = push_v && (!full || pop);
        drop   = push_v && full && !pop;
        rd_d   = pop ? rd_q + 2'd1 : rd_q;
        wr_d   = accept ? wr_q + 2'd1 : wr_q;
        case ({accept, pop})
            2'b10:   cnt_d = cnt_q + 3'd1;
            2'b01:   cnt_d = cnt_q - 3'd1;
            default: cnt_d = cnt_q;
        endcase
        ovf_d = ovf_q;
        if (drop) begin
            ovf_d = 1'b1;
        end else if (clear_overflow) begin
            ovf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            click_dly_q <= 1'b0;
            value_q     <= VALUE_W'(INIT_VALUE);
            sw_state_q  <= SW_IDLE;
            hold_q      <= '0;
            skid_v_q    <= 1'b0;
            skid_code_q <= '0;
            rd_q        <= '0;
            wr_q        <= '0;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            for (int unsigned i = 0; i < 4; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            click_dly_q <= click;
            value_q     <= value_d;
            sw_state_q  <= sw_state_d;
            hold_q      <= hold_d;
            skid_v_q    <= skid_v_d;
            skid_code_q <= skid_code_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            if (accept) begin
                mem_q[wr_q] <= push_code;
            end
        end
    end

    assign value     = value_q;
    assign evt_valid = (cnt_q != 3'd0);
    assign evt_code  = mem_q[rd_q];
    assign evt_count = cnt_q;
    assign overflow  = ovf_q;

endmodule

// File: tb/tb_encoder_event_tracker.sv
// Directed bench for encoder_event_tracker: vector table for detent/value behaviour plus
// hand sequences for presses, FIFO overflow/clear, simultaneous events and mid-press reset.
module tb_encoder_event_tracker;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       stb = 1'b0, cw = 1'b0, click = 1'b0, sw = 1'b1;
    logic       ready = 1'b0, clr = 1'b0;
    logic [7:0] value, value2;
    logic       valid, valid2;
    logic [1:0] code, code2;
    logic [2:0] count, count2;
    logic       ovf, ovf2;

    int checks = 0;
    int errors = 0;

    encoder_event_tracker #(
        .ACCEL_WINDOW(100), .LONG_PRESS_CYCLES(50), .INIT_VALUE(128)
    ) dut (
        .clk(clk), .reset(reset), .enc_state_change_stb(stb), .clockwise(cw),
        .click(click), .switch(sw), .value(value), .evt_valid(valid),
        .evt_code(code), .evt_ready(ready), .evt_count(count),
        .overflow(ovf), .clear_overflow(clr)
    );

    encoder_event_tracker #(
        .ACCEL_WINDOW(100), .LONG_PRESS_CYCLES(50), .INIT_VALUE(254)
    ) dut2 (
        .clk(clk), .reset(reset), .enc_state_change_stb(stb), .clockwise(cw),
        .click(click), .switch(sw), .value(value2), .evt_valid(valid2),
        .evt_code(code2), .evt_ready(ready), .evt_count(count2),
        .overflow(ovf2), .clear_overflow(clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit rst;
        bit dir;
        int gap;
        int exp_v;
        int exp_v2;
        int exp_cnt;
    } vec_t;

    vec_t vecs [5];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b0;
        stb = 1'b0; click = 1'b0; cw = 1'b0; sw = 1'b1; ready = 1'b0; clr = 1'b0;
        ticks(2);
        reset = 1'b1;
        tick();
    endtask

    task automatic detent(input logic dir);
        stb = 1'b1; click = 1'b1; cw = dir;
        tick();
        stb = 1'b0;
        tick();
        stb = 1'b1; click = 1'b0;
        tick();
        stb = 1'b0;
    endtask

    task automatic pop_one();
        ready = 1'b1;
        tick();
        ready = 1'b0;
    endtask

    task automatic run_vec(input int i);
        if (vecs[i].rst) do_reset();
        ticks(vecs[i].gap);
        detent(vecs[i].dir);
        check($sformatf("vec%0d_value", i), value, vecs[i].exp_v);
        check($sformatf("vec%0d_value_init254", i), value2, vecs[i].exp_v2);
        check($sformatf("vec%0d_count", i), count, vecs[i].exp_cnt);
        check($sformatf("vec%0d_count_init254", i), count2, vecs[i].exp_cnt);
    endtask

    initial begin
        logic [1:0] exp_codes [4];

        vecs[0] = '{rst: 1'b0, dir: 1'b1, gap: 500, exp_v: 129, exp_v2: 255, exp_cnt: 1};
        vecs[1] = '{rst: 1'b0, dir: 1'b1, gap: 500, exp_v: 130, exp_v2: 255, exp_cnt: 2};
        vecs[2] = '{rst: 1'b0, dir: 1'b1, gap: 500, exp_v: 131, exp_v2: 255, exp_cnt: 3};
        vecs[3] = '{rst: 1'b1, dir: 1'b0, gap: 500, exp_v: 127, exp_v2: 253, exp_cnt: 1};
`ifdef ENC_ACCEL_EN
        vecs[4] = '{rst: 1'b0, dir: 1'b0, gap: 20,  exp_v: 123, exp_v2: 249, exp_cnt: 2};
`else
        vecs[4] = '{rst: 1'b0, dir: 1'b0, gap: 20,  exp_v: 126, exp_v2: 252, exp_cnt: 2};
`endif

        do_reset();
        check("reset_value", value, 128);
        check("reset_value_init254", value2, 254);
        check("reset_valid", valid, 0);
        check("reset_count", count, 0);
        check("reset_overflow", ovf, 0);

        for (int i = 0; i < 3; i++) run_vec(i);
        for (int k = 0; k < 3; k++) begin
            check($sformatf("cw_code%0d", k), code, 0);
            check($sformatf("cw_code%0d_init254", k), code2, 0);
            pop_one();
        end
        check("cw_drained_valid", valid, 0);

        for (int i = 3; i < 5; i++) run_vec(i);
        for (int k = 0; k < 2; k++) begin
            check($sformatf("ccw_code%0d", k), code, 1);
            pop_one();
        end
        check("ccw_drained_count", count, 0);

        // Short press, 20 cycles
        do_reset();
        sw = 1'b0;
        ticks(20);
        check("short_none_while_held", count, 0);
        sw = 1'b1;
        tick();
        check("short_count", count, 1);
        check("short_code", code, 2);
        pop_one();
        check("short_popped", count, 0);

        // Longest press that still counts as short
        sw = 1'b0;
        ticks(49);
        sw = 1'b1;
        tick();
        check("short49_count", count, 1);
        check("short49_code", code, 2);
        pop_one();

        // Long press: event exactly at the threshold, nothing on release
        sw = 1'b0;
        ticks(50);
        check("long_not_yet", count, 0);
        tick();
        check("long_count", count, 1);
        check("long_code", code, 3);
        ticks(29);
        sw = 1'b1;
        ticks(3);
        check("long_release_silent", count, 1);
        pop_one();
        check("long_popped", count, 0);

        // Overflow: 6 detents with consumer stalled
        do_reset();
        detent(1'b1); detent(1'b0); detent(1'b1);
        detent(1'b0); detent(1'b1); detent(1'b1);
        check("ovf_count", count, 4);
        check("ovf_flag", ovf, 1);
`ifdef ENC_ACCEL_EN
        check("ovf_value", value, 133);
`else
        check("ovf_value", value, 130);
`endif
        check("ovf_value_init254", value2, 255);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("ovf_cleared", ovf, 0);

        // Clear coinciding with a fresh drop keeps the flag set
        stb = 1'b1; click = 1'b1; cw = 1'b1; clr = 1'b1;
        tick();
        stb = 1'b0; clr = 1'b0;
        check("ovf_clear_vs_drop", ovf, 1);
        tick();
        stb = 1'b1; click = 1'b0;
        tick();
        stb = 1'b0;
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("ovf_cleared_again", ovf, 0);

        // Push and pop together while full
        stb = 1'b1; click = 1'b1; cw = 1'b1; ready = 1'b1;
        tick();
        stb = 1'b0; ready = 1'b0;
        check("full_pushpop_count", count, 4);
        check("full_pushpop_ovf", ovf, 0);
        tick();
        stb = 1'b1; click = 1'b0;
        tick();
        stb = 1'b0;
        exp_codes[0] = 2'b01; exp_codes[1] = 2'b00;
        exp_codes[2] = 2'b01; exp_codes[3] = 2'b00;
        for (int k = 0; k < 4; k++) begin
            check($sformatf("drain_code%0d", k), code, exp_codes[k]);
            pop_one();
        end
        check("drain_valid", valid, 0);

        // Short-press release coincident with a CW detent
        do_reset();
        sw = 1'b0;
        ticks(20);
        sw = 1'b1; stb = 1'b1; click = 1'b1; cw = 1'b1;
        tick();
        stb = 1'b0;
        check("simul_first_count", count, 1);
        check("simul_first_code", code, 0);
        tick();
        check("simul_second_count", count, 2);
        stb = 1'b1; click = 1'b0;
        tick();
        stb = 1'b0;
        pop_one();
        check("simul_head_after_pop", code, 2);
        check("simul_count_after_pop", count, 1);
        pop_one();
        check("simul_drained", count, 0);

        // Reset in the middle of a press
        do_reset();
        detent(1'b1);
        sw = 1'b0;
        ticks(30);
        reset = 1'b0;
        tick();
        sw = 1'b1;
        tick();
        reset = 1'b1;
        ticks(60);
        check("midreset_count", count, 0);
        check("midreset_valid", valid, 0);
        check("midreset_value", value, 128);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
